osc_playback: RTL and testbench

Per-oscillator playback sequencer: the read side of the oscillator wave BRAMs filled by the wave loader. On each audio sample tick it advances a fixed-point phase accumulator per oscillator, drives the BRAM read address, and waits out the 2-cycle HIGH_PERFORMANCE read latency. It then registers one sample per oscillator and pulses a valid strobe toward the mixer. It also decides what a disabled oscillator outputs and what happens while the loader is rewriting the BRAMs.

---
 rtl/osc_playback.sv | 137 +++++++++++++
 tb/tb_osc_playback.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_playback.sv
// Per-oscillator playback sequencer: advances phase accumulators on each sample tick, drives the
// wave BRAM read addresses, waits out the 2-cycle read latency and captures one sample per
// oscillator. Optional macro PLAYBACK_MUTE_ON_LOAD_EN mutes playback while the loader is busy.
module osc_playback #(
  parameter int unsigned NUM_OSCILLATORS = 4,
  parameter int unsigned SAMPLE_WIDTH    = 16,
  parameter int unsigned WW_WIDTH        = 18,
  parameter int unsigned FRAC_BITS       = 8
) (
  input  logic                                                   clk_in,
  input  logic                                                   rst_in,
  input  logic                                                   sample_tick_in,
  input  logic [WW_WIDTH-1:0]                                    wave_width_in,
  input  logic                                                   loader_busy_in,
  input  logic [NUM_OSCILLATORS-1:0]                             osc_is_on_in,
  input  logic [NUM_OSCILLATORS-1:0][WW_WIDTH+FRAC_BITS-1:0]     osc_step_in,
  output logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0]               osc_index_out,
  input  logic [NUM_OSCILLATORS-1:0][SAMPLE_WIDTH-1:0]           osc_data_in,
  output logic [NUM_OSCILLATORS-1:0][SAMPLE_WIDTH-1:0]           osc_sample_out,
  output logic                                                   sample_valid_out,
  output logic                                                   overrun_out
);

  localparam int unsigned P = WW_WIDTH + FRAC_BITS;

  typedef enum logic [1:0] {StIdle, StWait, StCapture} state_e;

  state_e                                        state_q, state_d;
  logic                                          wait_cnt_q, wait_cnt_d;
  logic [NUM_OSCILLATORS-1:0][P-1:0]             phase_q, phase_d;
  logic [NUM_OSCILLATORS-1:0][SAMPLE_WIDTH-1:0]  sample_q, sample_d;
  logic [NUM_OSCILLATORS-1:0]                    on_q, on_d;
  logic                                          zero_q, zero_d;
  logic                                          valid_q, valid_d;
  logic                                          overrun_q, overrun_d;

  logic                                          mute;
  logic [P:0]                                    wave_len;
  logic [NUM_OSCILLATORS-1:0][P:0]               sum;
  logic [NUM_OSCILLATORS-1:0][P:0]               wrapped;
  logic [NUM_OSCILLATORS-1:0][P-1:0]             phase_adv;

`ifdef PLAYBACK_MUTE_ON_LOAD_EN
  assign mute = loader_busy_in;
`else
  logic unused_loader_busy;
  assign unused_loader_busy = loader_busy_in;
  assign mute = 1'b0;
`endif

  assign wave_len = {1'b0, wave_width_in, {FRAC_BITS{1'b0}}};

  // A second wrap still out of range (wave shrank under the phase) restarts at zero.
  always_comb begin
    sum       = '0;
    wrapped   = '0;
    phase_adv = '0;
    for (int i = 0; i < NUM_OSCILLATORS; i++) begin
      sum[i]     = {1'b0, phase_q[i]} + {1'b0, osc_step_in[i]};
      wrapped[i] = (sum[i] >= wave_len) ? sum[i] - wave_len : sum[i];
      if (osc_is_on_in[i] && (wave_width_in != '0) && !mute && (wrapped[i] < wave_len)) begin
        phase_adv[i] = wrapped[i][P-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    phase_d    = phase_q;
    sample_d   = sample_q;
    on_d       = on_q;
    zero_d     = zero_q;
    valid_d    = 1'b0;
    overrun_d  = overrun_q;

    if (sample_tick_in && (state_q != StIdle)) overrun_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (sample_tick_in) begin
          state_d    = StWait;
          wait_cnt_d = 1'b0;
          phase_d    = phase_adv;
          on_d       = osc_is_on_in;
          zero_d     = (wave_width_in == '0) || mute;
        end
      end
      StWait: begin
        if (wait_cnt_q) state_d = StCapture;
        else            wait_cnt_d = 1'b1;
      end
      StCapture: begin
        for (int i = 0; i < NUM_OSCILLATORS; i++) begin
          sample_d[i] = (on_q[i] && !zero_q) ? osc_data_in[i] : '0;
        end
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      wait_cnt_q <= 1'b0;
      phase_q    <= '0;
      sample_q   <= '0;
      on_q       <= '0;
      zero_q     <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      phase_q    <= phase_d;
      sample_q   <= sample_d;
      on_q       <= on_d;
      zero_q     <= zero_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    osc_index_out = '0;
    for (int i = 0; i < NUM_OSCILLATORS; i++) begin
      osc_index_out[i] = phase_q[i][P-1:FRAC_BITS];
    end
  end

  assign osc_sample_out   = sample_q;
  assign sample_valid_out = valid_q;
  assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_osc_playback.sv
// Bench for osc_playback: directed vector table, multi-cycle corner sequences and randomized
// ticks against an arithmetic phase model. Honours PLAYBACK_MUTE_ON_LOAD_EN if defined.
module tb_osc_playback;

  localparam int N  = 2;
  localparam int SW = 16;
  localparam int WW = 8;
  localparam int FB = 4;
  localparam int P  = WW + FB;

`ifdef PLAYBACK_MUTE_ON_LOAD_EN
  localparam bit Mute = 1'b1;
`else
  localparam bit Mute = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   tick = 1'b0;
  logic [WW-1:0]          ww = '0;
  logic                   busy = 1'b0;
  logic [N-1:0]           on = '0;
  logic [N-1:0][P-1:0]    step = '0;
  logic [N-1:0][WW-1:0]   idx;
  logic [N-1:0][SW-1:0]   data;
  logic [N-1:0][SW-1:0]   samp;
  logic                   valid;
  logic                   overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  osc_playback #(
    .NUM_OSCILLATORS(N),
    .SAMPLE_WIDTH   (SW),
    .WW_WIDTH       (WW),
    .FRAC_BITS      (FB)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .sample_tick_in  (tick),
    .wave_width_in   (ww),
    .loader_busy_in  (busy),
    .osc_is_on_in    (on),
    .osc_step_in     (step),
    .osc_index_out   (idx),
    .osc_data_in     (data),
    .osc_sample_out  (samp),
    .sample_valid_out(valid),
    .overrun_out     (overrun)
  );

  // Wave BRAM with registered address and registered output: mem[a] = 0x100 + a.
  logic [N-1:0][WW-1:0] bram_addr;
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      bram_addr[i] <= idx[i];
      data[i]      <= 16'h100 + 16'(bram_addr[i]);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One tick; checks index in T+1, valid latency, then captured samples.
  task automatic tick_check(input string nm, input logic [WW-1:0] e0, input logic [WW-1:0] e1,
                            input logic [SW-1:0] s0, input logic [SW-1:0] s1);
    int lat;
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    chk({nm, " idx0"}, 32'(idx[0]), 32'(e0));
    chk({nm, " idx1"}, 32'(idx[1]), 32'(e1));
    lat = 0;
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      if (valid) begin
        lat = k;
        break;
      end
    end
    chk({nm, " latency"}, 32'(lat), 32'd4);
    chk({nm, " samp0"}, 32'(samp[0]), 32'(s0));
    chk({nm, " samp1"}, 32'(samp[1]), 32'(s1));
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int next_phase(int ph, int st, int w, bit en, bit muted);
    int len;
    int s;
    if (!en || w == 0 || muted) return 0;
    len = w * (1 << FB);
    s = ph + st;
    if (s >= len) s = s - len;
    if (s >= len) s = 0;
    return s;
  endfunction

  typedef struct {
    logic [1:0]    en;
    logic [P-1:0]  st0;
    logic [P-1:0]  st1;
    logic [WW-1:0] w;
    logic [WW-1:0] i0;
    logic [WW-1:0] i1;
    logic [SW-1:0] s0;
    logic [SW-1:0] s1;
  } vec_t;

  vec_t tbl[19];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    int first;
    int mph[N];
    int ph;
    bit muted;
    logic [WW-1:0] ei[N];
    logic [SW-1:0] es[N];

    //          en     st0     st1     w      i0    i1    s0       s1
    tbl[0]  = '{2'b01, 12'h010, 12'h000, 8'd4,  8'd1, 8'd0, 16'h101, 16'h000};
    tbl[1]  = '{2'b01, 12'h010, 12'h000, 8'd4,  8'd2, 8'd0, 16'h102, 16'h000};
    tbl[2]  = '{2'b01, 12'h010, 12'h000, 8'd4,  8'd3, 8'd0, 16'h103, 16'h000};
    tbl[3]  = '{2'b01, 12'h010, 12'h000, 8'd4,  8'd0, 8'd0, 16'h100, 16'h000};
    tbl[4]  = '{2'b01, 12'h010, 12'h000, 8'd4,  8'd1, 8'd0, 16'h101, 16'h000};
    tbl[5]  = '{2'b01, 12'h010, 12'h000, 8'd4,  8'd2, 8'd0, 16'h102, 16'h000};
    tbl[6]  = '{2'b00, 12'h000, 12'h000, 8'd16, 8'd0, 8'd0, 16'h000, 16'h000};
    tbl[7]  = '{2'b01, 12'h008, 12'h000, 8'd16, 8'd0, 8'd0, 16'h100, 16'h000};
    tbl[8]  = '{2'b01, 12'h008, 12'h000, 8'd16, 8'd1, 8'd0, 16'h101, 16'h000};
    tbl[9]  = '{2'b01, 12'h008, 12'h000, 8'd16, 8'd1, 8'd0, 16'h101, 16'h000};
    tbl[10] = '{2'b01, 12'h008, 12'h000, 8'd16, 8'd2, 8'd0, 16'h102, 16'h000};
    tbl[11] = '{2'b00, 12'h000, 12'h000, 8'd4,  8'd0, 8'd0, 16'h000, 16'h000};
    tbl[12] = '{2'b01, 12'h050, 12'h000, 8'd4,  8'd1, 8'd0, 16'h101, 16'h000};
    tbl[13] = '{2'b01, 12'h050, 12'h000, 8'd4,  8'd2, 8'd0, 16'h102, 16'h000};
    tbl[14] = '{2'b10, 12'h000, 12'h030, 8'd16, 8'd0, 8'd3, 16'h000, 16'h103};
    tbl[15] = '{2'b10, 12'h000, 12'h030, 8'd16, 8'd0, 8'd6, 16'h000, 16'h106};
    tbl[16] = '{2'b00, 12'h000, 12'h030, 8'd16, 8'd0, 8'd0, 16'h000, 16'h000};
    tbl[17] = '{2'b10, 12'h000, 12'h030, 8'd16, 8'd0, 8'd3, 16'h000, 16'h103};
    tbl[18] = '{2'b11, 12'h010, 12'h030, 8'd0,  8'd0, 8'd0, 16'h000, 16'h000};

    // Reset held 3 cycles with a tick pulsing every cycle.
    on = 2'b11; step[0] = 12'h010; step[1] = 12'h010; ww = 8'd16;
    vcount = 0;
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1;
      @(negedge clk);
      if (valid === 1'b1) vcount++;
    end
    tick = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (valid !== 1'b0) vcount++;
    end
    chk("reset no valid", 32'(vcount), 32'd0);
    chk("reset idx0", 32'(idx[0]), 32'd0);
    chk("reset idx1", 32'(idx[1]), 32'd0);
    chk("reset samp0", 32'(samp[0]), 32'd0);
    chk("reset samp1", 32'(samp[1]), 32'd0);
    chk("reset overrun", 32'(overrun), 32'd0);

    foreach (tbl[r]) begin
      on = tbl[r].en; step[0] = tbl[r].st0; step[1] = tbl[r].st1; ww = tbl[r].w;
      tick_check($sformatf("vec%0d", r), tbl[r].i0, tbl[r].i1, tbl[r].s0, tbl[r].s1);
    end

    // Overrun: ticks at T and T+2 give one valid at T+4 and one phase advance.
    do_reset();
    on = 2'b01; step[0] = 12'h010; step[1] = '0; ww = 8'd16;
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    vcount = 0; first = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (valid) begin
        vcount++;
        if (first == 0) first = k;
      end
    end
    chk("overrun valid count", 32'(vcount), 32'd1);
    chk("overrun valid at T+4", 32'(first), 32'd1);
    chk("overrun idx0", 32'(idx[0]), 32'd1);
    chk("overrun flag", 32'(overrun), 32'd1);
    repeat (10) @(negedge clk);
    chk("overrun sticky", 32'(overrun), 32'd1);
    do_reset();
    @(negedge clk);
    chk("overrun cleared", 32'(overrun), 32'd0);

    // Reset in the middle of a sequence aborts without a valid pulse.
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    chk("midreset idx before", 32'(idx[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    vcount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    chk("midreset no valid", 32'(vcount), 32'd0);
    chk("midreset idx0", 32'(idx[0]), 32'd0);

    // Loader busy across 3 ticks, then one tick after release.
    do_reset();
    on = 2'b01; step[0] = 12'h010; step[1] = '0; ww = 8'd16; busy = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      if (Mute) tick_check($sformatf("busy%0d", t), 8'd0, 8'd0, 16'h0, 16'h0);
      else      tick_check($sformatf("busy%0d", t), 8'(t), 8'd0, 16'(16'h100 + t), 16'h0);
    end
    busy = 1'b0;
    if (Mute) tick_check("busy release", 8'd1, 8'd0, 16'h101, 16'h0);
    else      tick_check("busy release", 8'd4, 8'd0, 16'h104, 16'h0);

    // Randomized ticks against the arithmetic model.
    do_reset();
    mph[0] = 0; mph[1] = 0;
    for (int t = 0; t < 40; t++) begin
      on      = 2'($urandom_range(0, 3));
      step[0] = 12'($urandom_range(0, 4095));
      step[1] = 12'($urandom_range(0, 4095));
      ww      = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      busy    = 1'($urandom_range(0, 1));
      muted   = Mute && busy;
      for (int i = 0; i < N; i++) begin
        ph     = next_phase(mph[i], int'(step[i]), int'(ww), on[i], muted);
        mph[i] = ph;
        ei[i]  = 8'(ph >> FB);
        es[i]  = (on[i] && ww != 0 && !muted) ? 16'(16'h100 + (ph >> FB)) : 16'h0;
      end
      tick_check($sformatf("rand%0d", t), ei[0], ei[1], es[0], es[1]);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
